// File: rtl/seq_addsub64.sv
// Multi-cycle 64-bit add/subtract, one CHUNK-bit slice per clock.
// Produces result plus carry, overflow, zero and sign flags.
module seq_addsub64 #(
  parameter int CHUNK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero,
  output logic        sign
);

  localparam int NCHUNK = 64 / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        carry;
  logic [CW-1:0] cnt;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] low;
  logic             c63;
  logic [63:0]      full;

  // Operands shift right so the active slice is always the low CHUNK bits.
  always_comb begin
    ca   = op_a[CHUNK-1:0];
    cb   = op_b[CHUNK-1:0];
    sum  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    low  = {1'b0, ca[CHUNK-2:0]} + {1'b0, cb[CHUNK-2:0]}
         + {{(CHUNK-1){1'b0}}, carry};
    c63  = low[CHUNK-1];
    full = result;
    full[int'(cnt)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= op ? ~b : b;
            carry <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= full;
          carry  <= sum[CHUNK];
          op_a   <= op_a >> CHUNK;
          op_b   <= op_b >> CHUNK;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            carry_out <= sum[CHUNK];
            overflow  <= c63 ^ sum[CHUNK];
            zero      <= (full == 64'd0);
            sign      <= full[63];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub64.sv
// Self-checking bench for seq_addsub64 with CHUNK=16.
// Reference model uses plain 65-bit arithmetic and signed overflow rules.
module tb_seq_addsub64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        sign;

  int checks = 0;
  int failures = 0;

  seq_addsub64 #(.CHUNK(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  // {result, carry_out, overflow, zero, sign}
  function automatic logic [67:0] model(input logic o,
                                        input logic [63:0] x,
                                        input logic [63:0] y);
    logic [64:0] full;
    logic [63:0] r;
    logic ov;
    if (o) full = {1'b0, x} - {1'b0, y};
    else   full = {1'b0, x} + {1'b0, y};
    r = full[63:0];
    if (o) ov = (x[63] != y[63]) && (r[63] != x[63]);
    else   ov = (x[63] == y[63]) && (r[63] != x[63]);
    // For subtraction carry means no borrow.
    return {r, o ? ~full[64] : full[64], ov, r == 64'd0, r[63]};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [67:0] observed();
    return {result, carry_out, overflow, zero, sign};
  endfunction

  // Called #1 after an edge with busy=0; returns cycles to done or -1.
  task automatic run_op(input logic o, input logic [63:0] x,
                        input logic [63:0] y, output int lat);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = $urandom; a = r64(); b = r64();
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, observed()} !== 70'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {busy, done, observed()});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [63:0] da [6];
    logic [63:0] db [6];
    logic        dop [6];
    logic [67:0] exp;
    int lat;
    dop[0] = 0; da[0] = 64'd5; db[0] = 64'd7;
    dop[1] = 1; da[1] = 64'h1234_5678_9ABC_DEF0; db[1] = da[1];
    dop[2] = 0; da[2] = 64'h7FFF_FFFF_FFFF_FFFF; db[2] = 64'd1;
    dop[3] = 1; da[3] = 64'h8000_0000_0000_0000; db[3] = 64'd1;
    dop[4] = 0; da[4] = '1; db[4] = 64'd1;
    dop[5] = 1; da[5] = 64'd9; db[5] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      run_op(dop[i], da[i], db[i], lat);
      exp = model(dop[i], da[i], db[i]);
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d want=4", i, lat);
      end
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL dir%0d_value got=%h want=%h", i, observed(), exp);
      end
    end
    // Spot-check hand-derived values independent of the model.
    checks++;
    if (observed() !== {64'h8000_0000_0000_0009, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL dir_sub_min got=%h", observed());
    end
  endtask

  task automatic test_random();
    logic [63:0] x, y;
    logic o;
    logic [67:0] exp;
    int lat;
    for (int i = 0; i < 150; i++) begin
      x = r64(); y = r64(); o = $urandom;
      if (i % 10 == 3) y = x;
      if (i % 10 == 7) x = ~y;
      run_op(o, x, y, lat);
      exp = model(o, x, y);
      checks++;
      if (lat != 4 || observed() !== exp) begin
        failures++;
        $display("FAIL rand%0d lat=%0d got=%h want=%h", i, lat,
                 observed(), exp);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [67:0] exp;
    int lat;
    exp = model(1'b0, 64'd100, 64'd23);
    start = 1'b1; op = 1'b0; a = 64'd100; b = 64'd23;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_high got=%b want=1", busy);
    end
    start = 1'b1; op = 1'b1; a = '1; b = 64'd55;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 2; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat != 4 || observed() !== exp) begin
      failures++;
      $display("FAIL busy_ignore lat=%0d got=%h want=%h", lat,
               observed(), exp);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_no_second got done=%b busy=%b want 0 0",
               done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 64'd5, 64'd7, lat);
    checks++;
    if (lat != 4 || result !== 64'd12 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first lat=%0d got=%h busy=%b want 12", lat,
               result, busy);
    end
    run_op(1'b1, 64'd3, 64'd5, lat);
    checks++;
    if (lat != 4 ||
        observed() !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second lat=%0d got=%h want=fffffffffffffffe/0001",
               lat, observed());
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    start = 1'b1; op = 1'b0; a = 64'd40; b = 64'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, observed()} !== 70'd0) begin
      failures++;
      $display("FAIL reset_midop got=%h want=0", {busy, done, observed()});
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_done got=%0d active cycles want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
